// File: rtl/lcplc_block_flagger.sv
// Tags a block-ordered, band-sequential sample stream with row/slice/block/image last flags.
// Geometry is latched on the first beat of each image; the output has a single register stage.
module lcplc_block_flagger #(
   parameter int unsigned DATA_WIDTH         = 16,
   parameter int unsigned MAX_SLICE_SIZE_LOG = 8,
   parameter int unsigned BAND_WIDTH         = 10,
   parameter int unsigned BLOCK_COUNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [MAX_SLICE_SIZE_LOG/2:0]   cfg_block_w,
   input  logic [MAX_SLICE_SIZE_LOG/2:0]   cfg_block_h,
   input  logic [BAND_WIDTH-1:0]           cfg_bands,
   input  logic [BLOCK_COUNT_WIDTH-1:0]    cfg_blocks,
   input  logic                            input_valid,
   output logic                            input_ready,
   input  logic [DATA_WIDTH-1:0]           input_data,
   output logic                            output_valid,
   input  logic                            output_ready,
   output logic [DATA_WIDTH-1:0]           output_data,
   output logic                            output_last_r,
   output logic                            output_last_s,
   output logic                            output_last_b,
   output logic                            output_last_i,
   output logic                            busy
);

   localparam int unsigned DimW = MAX_SLICE_SIZE_LOG / 2 + 1;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                         state_q, state_d;
   logic [DimW-1:0]                w_q, w_d, h_q, h_d;
   logic [BAND_WIDTH-1:0]          bands_q, bands_d;
   logic [BLOCK_COUNT_WIDTH-1:0]   blocks_q, blocks_d;
   logic [DimW-1:0]                col_q, col_d, row_q, row_d;
   logic [BAND_WIDTH-1:0]          band_q, band_d;
   logic [BLOCK_COUNT_WIDTH-1:0]   blk_q, blk_d;
   logic                           out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
   logic [3:0]                     out_flags_q, out_flags_d;
   logic                           busy_q, busy_d;

   logic [DimW-1:0]                w_eff, h_eff, w_m1, h_m1;
   logic [BAND_WIDTH-1:0]          bands_eff, bands_m1;
   logic [BLOCK_COUNT_WIDTH-1:0]   blocks_eff, blocks_m1;
   logic                           last_r, last_s, last_b, last_i;
   logic                           accept;

   assign input_ready = !out_valid_q | output_ready;
   assign accept      = input_valid & input_ready;

   // The first beat of an image is flagged against the live cfg it is about to latch.
   always_comb begin
      if (state_q == StIdle) begin
         w_eff      = cfg_block_w;
         h_eff      = cfg_block_h;
         bands_eff  = cfg_bands;
         blocks_eff = cfg_blocks;
      end else begin
         w_eff      = w_q;
         h_eff      = h_q;
         bands_eff  = bands_q;
         blocks_eff = blocks_q;
      end
      w_m1      = (w_eff == '0) ? '0 : w_eff - DimW'(1);
      h_m1      = (h_eff == '0) ? '0 : h_eff - DimW'(1);
      bands_m1  = (bands_eff == '0) ? '0 : bands_eff - BAND_WIDTH'(1);
      blocks_m1 = (blocks_eff == '0) ? '0 : blocks_eff - BLOCK_COUNT_WIDTH'(1);
   end

   assign last_r = (col_q == w_m1);
   assign last_s = last_r & (row_q == h_m1);
   assign last_b = last_s & (band_q == bands_m1);
   assign last_i = last_b & (blk_q == blocks_m1);

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      h_d         = h_q;
      bands_d     = bands_q;
      blocks_d    = blocks_q;
      col_d       = col_q;
      row_d       = row_q;
      band_d      = band_q;
      blk_d       = blk_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_flags_d = out_flags_q;
      busy_d      = (state_q == StRun);

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = input_data;
         out_flags_d = {last_i, last_b, last_s, last_r};
         // A single-beat image still produces a one-cycle busy pulse.
         busy_d      = (state_q == StIdle) | !last_i;

         if (state_q == StIdle) begin
            w_d      = cfg_block_w;
            h_d      = cfg_block_h;
            bands_d  = cfg_bands;
            blocks_d = cfg_blocks;
         end

         if (last_i) begin
            state_d = StIdle;
            col_d   = '0;
            row_d   = '0;
            band_d  = '0;
            blk_d   = '0;
         end else begin
            state_d = StRun;
            if (last_r) begin
               col_d = '0;
               if (last_s) begin
                  row_d = '0;
                  if (last_b) begin
                     band_d = '0;
                     blk_d  = blk_q + BLOCK_COUNT_WIDTH'(1);
                  end else begin
                     band_d = band_q + BAND_WIDTH'(1);
                  end
               end else begin
                  row_d = row_q + DimW'(1);
               end
            end else begin
               col_d = col_q + DimW'(1);
            end
         end
      end else if (output_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         w_q         <= '0;
         h_q         <= '0;
         bands_q     <= '0;
         blocks_q    <= '0;
         col_q       <= '0;
         row_q       <= '0;
         band_q      <= '0;
         blk_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_flags_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         h_q         <= h_d;
         bands_q     <= bands_d;
         blocks_q    <= blocks_d;
         col_q       <= col_d;
         row_q       <= row_d;
         band_q      <= band_d;
         blk_q       <= blk_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_flags_q <= out_flags_d;
         busy_q      <= busy_d;
      end
   end

   assign output_valid  = out_valid_q;
   assign output_data   = out_data_q;
   assign output_last_r = out_flags_q[0];
   assign output_last_s = out_flags_q[1];
   assign output_last_b = out_flags_q[2];
   assign output_last_i = out_flags_q[3];
   assign busy          = busy_q;

endmodule

// File: tb/tb_lcplc_block_flagger.sv
// Directed bench for lcplc_block_flagger: geometry runs, backpressure, config isolation,
// mid-image reset and degenerate single-sample images.
module tb_lcplc_block_flagger;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  cfg_block_w, cfg_block_h;
   logic [9:0]  cfg_bands;
   logic [15:0] cfg_blocks;
   logic        input_valid, input_ready;
   logic [15:0] input_data;
   logic        output_valid, output_ready;
   logic [15:0] output_data;
   logic        output_last_r, output_last_s, output_last_b, output_last_i;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lcplc_block_flagger dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_block_w   (cfg_block_w),
      .cfg_block_h   (cfg_block_h),
      .cfg_bands     (cfg_bands),
      .cfg_blocks    (cfg_blocks),
      .input_valid   (input_valid),
      .input_ready   (input_ready),
      .input_data    (input_data),
      .output_valid  (output_valid),
      .output_ready  (output_ready),
      .output_data   (output_data),
      .output_last_r (output_last_r),
      .output_last_s (output_last_s),
      .output_last_b (output_last_b),
      .output_last_i (output_last_i),
      .busy          (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int one_min(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // Expected {last_i, last_b, last_s, last_r} for zero-based sample k of an image.
   function automatic logic [3:0] exp_flags(input int k, input int w, input int h,
                                            input int b, input int n);
      int col, row, band, blk;
      logic r, s, bb, i;
      col  = k % w;
      row  = (k / w) % h;
      band = (k / (w * h)) % b;
      blk  = (k / (w * h * b)) % n;
      r    = (col == w - 1);
      s    = r && (row == h - 1);
      bb   = s && (band == b - 1);
      i    = bb && (blk == n - 1);
      return {i, bb, s, r};
   endfunction

   function automatic logic [3:0] out_flags();
      return {output_last_i, output_last_b, output_last_s, output_last_r};
   endfunction

   // Streams n_feed beats of an image and checks every output beat; bp selects the 1-of-3
   // ready pattern. If chg_at >= 0, cfg_block_w becomes chg_w once chg_at beats are accepted.
   task automatic run_image(input int w, input int h, input int b, input int n,
                            input int n_feed, input bit bp, input int chg_at,
                            input int chg_w, input logic [15:0] base);
      int in_idx = 0, out_idx = 0, cyc = 0;
      int ew, eh, eb, en, img;
      bit started = 0, done = 0, acc = 0, acc_prev = 0, stall_prev = 0;
      logic [15:0] hold_d;
      logic [3:0]  hold_f;
      ew  = one_min(w);
      eh  = one_min(h);
      eb  = one_min(b);
      en  = one_min(n);
      img = ew * eh * eb * en;
      @(posedge clk);
      #1;
      cfg_block_w  = 5'(w);
      cfg_block_h  = 5'(h);
      cfg_bands    = 10'(b);
      cfg_blocks   = 16'(n);
      output_ready = bp ? 1'b0 : 1'b1;
      input_valid  = 1'b1;
      input_data   = base;
      while (out_idx < n_feed && cyc < 8 * n_feed + 20) begin
         @(negedge clk);
         if (stall_prev) begin
            check_eq("stall_valid", output_valid, 1);
            check_eq("stall_data", output_data, hold_d);
            check_eq("stall_flags", out_flags(), hold_f);
         end
         if (!bp) check_eq("latency", output_valid, acc_prev);
         check_eq("busy", busy, started && !done);
         if (output_valid && !output_ready) check_eq("stall_in_rdy", input_ready, 0);
         if (output_valid && output_ready) begin
            check_eq("data", output_data, base + 16'(out_idx));
            check_eq("flags", out_flags(), exp_flags(out_idx, ew, eh, eb, en));
            out_idx++;
         end
         stall_prev = output_valid && !output_ready;
         hold_d     = output_data;
         hold_f     = out_flags();
         acc        = input_valid && input_ready;
         if (out_idx == n_feed) break;
         @(posedge clk);
         #1;
         if (acc) begin
            started = 1;
            if (in_idx == img - 1) done = 1;
            in_idx++;
         end
         acc_prev = acc;
         cyc++;
         if (in_idx == chg_at) cfg_block_w = 5'(chg_w);
         output_ready = bp ? (cyc % 3 == 0) : 1'b1;
         input_valid  = (in_idx < n_feed);
         input_data   = base + 16'(in_idx);
      end
      check_eq("beats_out", out_idx, n_feed);
   endtask

   initial begin
      rst          = 1'b0;
      cfg_block_w  = '0;
      cfg_block_h  = '0;
      cfg_bands    = '0;
      cfg_blocks   = '0;
      input_valid  = 1'b0;
      input_data   = '0;
      output_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", output_valid, 0);
      check_eq("rst_data", output_data, 0);
      check_eq("rst_flags", out_flags(), 0);
      check_eq("rst_busy", busy, 0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_in_rdy", input_ready, 1);

      // Basic image, then the same under backpressure.
      run_image(2, 2, 3, 2, 24, 1'b0, -1, 0, 16'h1000);
      run_image(2, 2, 3, 2, 24, 1'b1, -1, 0, 16'h2000);

      // cfg_block_w changes mid-image; the next image picks it up.
      run_image(2, 2, 3, 2, 24, 1'b0, 5, 4, 16'h3000);
      run_image(4, 2, 3, 2, 48, 1'b0, -1, 0, 16'h4000);

      // Reset while sample 9 sits in the output register.
      run_image(2, 2, 3, 2, 10, 1'b0, -1, 0, 16'h5000);
      rst = 1'b0;
      #1;
      check_eq("midrst_valid", output_valid, 0);
      check_eq("midrst_flags", out_flags(), 0);
      check_eq("midrst_busy", busy, 0);
      input_valid = 1'b0;
      @(negedge clk);
      check_eq("midrst_valid_hold", output_valid, 0);
      rst = 1'b1;
      run_image(2, 2, 3, 2, 24, 1'b0, -1, 0, 16'h6000);

      run_image(16, 16, 1, 1, 256, 1'b0, -1, 0, 16'h7000);

      // Degenerate geometry: every beat is a whole image.
      @(posedge clk);
      #1;
      cfg_block_w  = '0;
      cfg_block_h  = '0;
      cfg_bands    = '0;
      cfg_blocks   = '0;
      output_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         input_valid = 1'b1;
         input_data  = 16'hD000 + 16'(k);
         @(negedge clk);
         check_eq("degen_in_rdy", input_ready, 1);
         @(posedge clk);
         #1;
         input_valid = 1'b0;
         @(negedge clk);
         check_eq("degen_valid", output_valid, 1);
         check_eq("degen_data", output_data, 16'hD000 + 16'(k));
         check_eq("degen_flags", out_flags(), 4'hF);
         check_eq("degen_busy_hi", busy, 1);
         @(negedge clk);
         check_eq("degen_drain", output_valid, 0);
         check_eq("degen_busy_lo", busy, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lcplc_block_flagger.md
# lcplc_block_flagger

Upstream stage of the LCPLC coder: accepts a raw AXI-Stream of samples already ordered block by block, band-sequential within each block, and re-emits them with the four hierarchy flags the coder's `x_*` port consumes: `last_r` (row), `last_s` (slice), `last_b` (block) and `last_i` (image). Flags are derived from runtime-configured block geometry by a chain of cascaded counters. The output has one register stage and connects directly to the coder's `x_valid`/`x_ready`/`x_data`/`x_last_*`.

## Interface
- DATA_WIDTH, 16, sample width.
- MAX_SLICE_SIZE_LOG, 8, log2 of the maximum samples per slice; each block dimension is at most 2^(MAX_SLICE_SIZE_LOG/2).
- BAND_WIDTH, 10, width of the band count.
- BLOCK_COUNT_WIDTH, 16, width of the block count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- cfg_block_w  in  MAX_SLICE_SIZE_LOG/2+1  samples per block row.
- cfg_block_h  in  MAX_SLICE_SIZE_LOG/2+1  rows per block.
- cfg_bands  in  BAND_WIDTH  number of bands.
- cfg_blocks  in  BLOCK_COUNT_WIDTH  number of blocks in the image.
- input_valid / input_ready  in / out  1  upstream handshake.
- input_data  in  DATA_WIDTH  sample.
- output_valid / output_ready  out / in  1  downstream handshake.
- output_data  out  DATA_WIDTH  registered sample.
- output_last_r, output_last_s, output_last_b, output_last_i  out  1  flags aligned with output_data.
- busy  out  1  high while an image is in progress (from config latch until the last_i beat is accepted at the input).

## Operation
- FSM states:
  - IDLE: counters are zero. The first accepted input beat latches all cfg_* inputs into shadow registers and moves to RUN. That beat is counted as sample 0.
  - RUN: cfg_* inputs are ignored; only the shadow copies are used.
  - On acceptance of the beat that carries last_i, the FSM returns to IDLE.
- A cfg value of 0 is treated as 1.
- Counters, all zero-based, advance once per accepted input beat:
  - col wraps at w-1 and carries into row.
  - row wraps at h-1 and carries into band.
  - band wraps at bands-1 and carries into blk.
  - blk wraps at blocks-1.
- Flag terms for the current beat:
  - last_r = (col==w-1)
  - last_s = last_r & (row==h-1)
  - last_b = last_s & (band==bands-1)
  - last_i = last_b & (blk==blocks-1)
- Flags are computed combinationally from the counters and the shadow config, then registered together with the data.
- Invariant: last_i ⇒ last_b ⇒ last_s ⇒ last_r.
- When last_i is accepted, all counters clear to 0 in the same cycle.
- Counter widths: col/row use MAX_SLICE_SIZE_LOG/2+1 bits, band uses BAND_WIDTH bits, blk uses BLOCK_COUNT_WIDTH bits. There is no overflow, because each counter compares against count-1 before incrementing.
- Data passes through unmodified.

## Timing
- Output register: input_ready = !output_valid | output_ready. An input beat is accepted when input_valid & input_ready.
- Latency: a beat accepted in cycle N is presented on the output in cycle N+1.
- Throughput: one beat per cycle under continuous output_ready.
- Backpressure:
  - While output_valid & !output_ready, the output register holds data and flags stable and input_ready is low.
  - output_valid must never drop without a handshake.
- Simultaneous events: the output drains and a new input loads in the same cycle with no bubble.
- Reset values:
  - output_valid=0, output_data=0, all output_last_*=0.
  - busy=0, state IDLE, all counters 0, shadow config 0.
  - input_ready=1 once rst is deasserted.
- Reset mid-image: all state clears asynchronously. The next accepted beat restarts at sample 0 with freshly latched config.
- cfg_* changes during RUN have no effect until the next IDLE→RUN transition.
- busy rises in the cycle after the latching beat and falls in the cycle after the last_i beat is accepted at the input.

## Test plan
- Basic: w=2, h=2, bands=3, blocks=2; stream samples 0..23 with output_ready=1. Require:
  - last_r on samples 1,3,5,…,23.
  - last_s on samples 3,7,11,15,19,23.
  - last_b on samples 11 and 23.
  - last_i on sample 23 only.
  - Each output appears 1 cycle after its input; busy deasserts after sample 23.
- Backpressure: same config, output_ready toggled with a 1-of-3 pattern. Require the identical 24-beat data/flag sequence, with data and flags held stable on every stalled cycle and no beat lost or duplicated.
- Config isolation: change cfg_block_w from 2 to 4 at sample 5 of the basic run. Require the flag positions to stay unchanged. A following image then uses w=4, with last_r on samples 3,7,….
- Reset mid-image: assert rst low at sample 10, then release it and stream the basic config again. Require output_valid=0 during reset and the flag sequence to restart from sample 0.
- Maximum geometry: w=16, h=16, bands=1, blocks=1; stream 256 samples. Require last_r every 16th sample, and last_s, last_b and last_i together only on sample 255.
- Degenerate: w=h=bands=blocks=0 (treated as 1). Require every beat to carry all four flags set, and busy to pulse for one cycle per beat.
